bounce_generator: RTL and testbench

Emulates a mechanical contact bounce. A clean, clock-synchronous level on `in_0` becomes a chattering `out_0` that toggles at pseudo-random intervals for a fixed window, then settles at the new level. The block drives button-debounce logic in loopback benches and on hardware self-test builds. It is the transmitting end of the debounce path.

---
 rtl/bounce_generator_if.sv | 10 +
 rtl/bounce_generator.sv | 112 +++++++++++
 tb/tb_bounce_generator.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bounce_generator_if.sv
// Contact-side signals of the bounce generator: clean level in, chattering
// contact and window flag out.
interface bounce_generator_if;
    logic in_0;
    logic out_0;
    logic busy;

    modport master (output in_0, input out_0, input busy);
    modport slave  (input in_0, output out_0, output busy);
endinterface

// File: rtl/bounce_generator.sv
// Mechanical contact bounce emulator: a level change on in_0 becomes a chattering
// out_0 for BOUNCE_CYCLES clocks. Define BOUNCE_GENERATOR_RETRIGGER_EN to restart
// the window when in_0 moves again mid-bounce.
module bounce_generator #(
    parameter int unsigned BOUNCE_CYCLES = 200000,
    parameter int unsigned DWELL_BITS    = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset_n,
    bounce_generator_if.slave bus
);
    localparam int CNT_W   = $clog2(BOUNCE_CYCLES + 1);
    localparam int DWELL_W = DWELL_BITS + 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] ONE_DW   = DWELL_W'(1);

    typedef enum logic {IDLE, BOUNCE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_d;
    logic               level_q, level_d;
    logic               target_q, target_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_load;
    logic               retrigger;

    // Fibonacci LFSR, taps 16/14/13/11, free-running in every state.
    assign lfsr_d     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign dwell_load = DWELL_W'(lfsr[DWELL_BITS-1:0]) + ONE_DW;

`ifdef BOUNCE_GENERATOR_RETRIGGER_EN
    assign retrigger = (state_q == BOUNCE) && (bus.in_0 != target_q);
`else
    assign retrigger = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        out_d    = out_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_0 != level_q) begin
                    target_d = bus.in_0;
                    out_d    = bus.in_0;
                    cnt_d    = '0;
                    dwell_d  = dwell_load;
                    busy_d   = 1'b1;
                    state_d  = BOUNCE;
                end
            end
            BOUNCE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dwell_q == ONE_DW) begin
                    out_d   = ~out_q;
                    dwell_d = dwell_load;
                end else begin
                    dwell_d = dwell_q - ONE_DW;
                end
                // A retrigger restarts the window and leaves the contact untouched this cycle;
                // otherwise settling overrides a coinciding toggle.
                if (retrigger) begin
                    target_d = bus.in_0;
                    cnt_d    = '0;
                    out_d    = out_q;
                end else if (cnt_q == LAST_CNT) begin
                    out_d   = target_q;
                    level_d = target_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lfsr     <= LFSR_SEED;
            level_q  <= 1'b0;
            target_q <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            dwell_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            lfsr     <= lfsr_d;
            level_q  <= level_d;
            target_q <= target_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
        end
    end

    assign bus.out_0 = out_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: a 16-cycle/2-bit-dwell instance and a
// 1-cycle-window instance sharing clock and reset.
module tb_bounce_generator;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    logic [15:0] lfsr_model;

    bounce_generator_if bif ();
    bounce_generator_if bif1 ();

    bounce_generator #(.BOUNCE_CYCLES(16), .DWELL_BITS(2), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bif)
    );
    bounce_generator #(.BOUNCE_CYCLES(1), .DWELL_BITS(2), .LFSR_SEED(16'hACE1)) dut_short (
        .clock(clock), .reset_n(reset_n), .bus(bif1)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_model <= 16'hACE1;
        else lfsr_model <= {lfsr_model[14:0],
                            lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        bif.in_0 = 1'b0;
        bif1.in_0 = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        bif.in_0 = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if ({bif.out_0, bif.busy} !== 2'b00) begin
                n_bad++; $display("FAIL reset_hold cyc %0d: out,busy=%b want 00", i, {bif.out_0, bif.busy});
            end
        end
        n_cmp++;
        if (dut.lfsr !== 16'hACE1) begin n_bad++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr); end
        reset_n = 1'b1;
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b11) begin
            n_bad++; $display("FAIL reset_release: out,busy=%b want 11", {bif.out_0, bif.busy});
        end
        step(16);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b10) begin
            n_bad++; $display("FAIL reset_settle: out,busy=%b want 10", {bif.out_0, bif.busy});
        end
    endtask

    task automatic test_single_press;
        int   toggles;
        logic prev;
        do_reset();
        bif.in_0 = 1'b1;
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b11) begin
            n_bad++; $display("FAIL press_contact: out,busy=%b want 11", {bif.out_0, bif.busy});
        end
        toggles = 0;
        prev = bif.out_0;
        for (int i = 2; i <= 16; i++) begin
            step(1);
            n_cmp++;
            if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL press_busy k+%0d: got %b want 1", i, bif.busy); end
            if (bif.out_0 !== prev) toggles++;
            prev = bif.out_0;
        end
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b10) begin
            n_bad++; $display("FAIL press_settle: out,busy=%b want 10", {bif.out_0, bif.busy});
        end
        n_cmp++;
        if (toggles < 3) begin n_bad++; $display("FAIL press_toggles: got %0d want >=3", toggles); end
        for (int i = 0; i < 50; i++) begin
            step(1);
            n_cmp++;
            if ({bif.out_0, bif.busy} !== 2'b10) begin
                n_bad++; $display("FAIL press_stable cyc %0d: out,busy=%b want 10", i, {bif.out_0, bif.busy});
            end
        end
        bif.in_0 = 1'b0;
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b01) begin
            n_bad++; $display("FAIL release_contact: out,busy=%b want 01", {bif.out_0, bif.busy});
        end
        step(16);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b00) begin
            n_bad++; $display("FAIL release_settle: out,busy=%b want 00", {bif.out_0, bif.busy});
        end
    endtask

    task automatic test_dwell_bounds;
        int   busy_cnt;
        int   run_len;
        logic prev_out;
        do_reset();
        for (int w = 0; w < 200; w++) begin
            bif.in_0 = ~bif.in_0;
            busy_cnt = 0;
            run_len = 0;
            prev_out = 1'b0;
            for (int c = 0; c < 40; c++) begin
                step(1);
                n_cmp++;
                if (dut.lfsr !== lfsr_model) begin
                    n_bad++; $display("FAIL lfsr_seq win %0d: got %h want %h", w, dut.lfsr, lfsr_model);
                end
                if (bif.busy === 1'b1) begin
                    busy_cnt++;
                    if (busy_cnt == 1) begin
                        run_len = 1;
                    end else if (bif.out_0 !== prev_out) begin
                        n_cmp++;
                        if (run_len < 1 || run_len > 4) begin
                            n_bad++; $display("FAIL dwell_len win %0d: got %0d want 1..4", w, run_len);
                        end
                        run_len = 1;
                    end else begin
                        run_len++;
                    end
                    prev_out = bif.out_0;
                end else if (busy_cnt > 0) begin
                    break;
                end
            end
            n_cmp++;
            if (busy_cnt != 16) begin n_bad++; $display("FAIL window_len win %0d: got %0d want 16", w, busy_cnt); end
            n_cmp++;
            if (bif.out_0 !== bif.in_0) begin
                n_bad++; $display("FAIL window_settle win %0d: got %b want %b", w, bif.out_0, bif.in_0);
            end
            repeat ($urandom_range(0, 3)) begin
                step(1);
                n_cmp++;
                if (dut.lfsr !== lfsr_model) begin
                    n_bad++; $display("FAIL lfsr_gap win %0d: got %h want %h", w, dut.lfsr, lfsr_model);
                end
            end
        end
    endtask

    task automatic test_retrigger;
        do_reset();
        bif.in_0 = 1'b1;
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b11) begin
            n_bad++; $display("FAIL retrig_contact: out,busy=%b want 11", {bif.out_0, bif.busy});
        end
        step(4);
        bif.in_0 = 1'b0;
`ifdef BOUNCE_GENERATOR_RETRIGGER_EN
        for (int i = 6; i <= 21; i++) begin
            step(1);
            n_cmp++;
            if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL retrig_busy k+%0d: got %b want 1", i, bif.busy); end
        end
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b00) begin
            n_bad++; $display("FAIL retrig_settle k+22: out,busy=%b want 00", {bif.out_0, bif.busy});
        end
`else
        for (int i = 6; i <= 16; i++) begin
            step(1);
            n_cmp++;
            if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy k+%0d: got %b want 1", i, bif.busy); end
        end
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b10) begin
            n_bad++; $display("FAIL ignore_settle k+17: out,busy=%b want 10", {bif.out_0, bif.busy});
        end
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b01) begin
            n_bad++; $display("FAIL ignore_restart k+18: out,busy=%b want 01", {bif.out_0, bif.busy});
        end
        for (int i = 19; i <= 33; i++) begin
            step(1);
            n_cmp++;
            if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy2 k+%0d: got %b want 1", i, bif.busy); end
        end
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b00) begin
            n_bad++; $display("FAIL ignore_settle2 k+34: out,busy=%b want 00", {bif.out_0, bif.busy});
        end
`endif
    endtask

    task automatic test_async_reset;
        do_reset();
        bif.in_0 = 1'b1;
        step(8);
        n_cmp++;
        if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL areset_pre: busy=%b want 1", bif.busy); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b00) begin
            n_bad++; $display("FAIL areset_outputs: out,busy=%b want 00", {bif.out_0, bif.busy});
        end
        n_cmp++;
        if (dut.lfsr !== 16'hACE1) begin n_bad++; $display("FAIL areset_lfsr: got %h want ace1", dut.lfsr); end
        #2;
        reset_n = 1'b1;
        step(1);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b11) begin
            n_bad++; $display("FAIL areset_restart: out,busy=%b want 11", {bif.out_0, bif.busy});
        end
        step(16);
        n_cmp++;
        if ({bif.out_0, bif.busy} !== 2'b10) begin
            n_bad++; $display("FAIL areset_settle: out,busy=%b want 10", {bif.out_0, bif.busy});
        end
    endtask

    task automatic test_short_window;
        do_reset();
        bif1.in_0 = 1'b1;
        step(1);
        n_cmp++;
        if ({bif1.out_0, bif1.busy} !== 2'b11) begin
            n_bad++; $display("FAIL short_contact: out,busy=%b want 11", {bif1.out_0, bif1.busy});
        end
        for (int i = 2; i <= 9; i++) begin
            step(1);
            n_cmp++;
            if ({bif1.out_0, bif1.busy} !== 2'b10) begin
                n_bad++; $display("FAIL short_settled k+%0d: out,busy=%b want 10", i, {bif1.out_0, bif1.busy});
            end
        end
        bif1.in_0 = 1'b0;
        step(1);
        n_cmp++;
        if ({bif1.out_0, bif1.busy} !== 2'b01) begin
            n_bad++; $display("FAIL short_release: out,busy=%b want 01", {bif1.out_0, bif1.busy});
        end
        step(1);
        n_cmp++;
        if ({bif1.out_0, bif1.busy} !== 2'b00) begin
            n_bad++; $display("FAIL short_release_settle: out,busy=%b want 00", {bif1.out_0, bif1.busy});
        end
    endtask

    initial begin
        bif.in_0 = 1'b0;
        bif1.in_0 = 1'b0;
        test_reset();
        test_single_press();
        test_dwell_bounds();
        test_retrigger();
        test_async_reset();
        test_short_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
